// File: rtl/additive_bin_scheduler_if.sv
// Sample-request, configuration and ROM-lookup signals of the additive bin scheduler.
// The design side uses the slave modport; the driving side (ROM, LRCK logic, config) uses master.
interface additive_bin_scheduler_if #(
    parameter int PHASE_W = 16
);
    logic               sample_req;
    logic               cfg_we;
    logic [3:0]         cfg_bin;
    logic [PHASE_W-1:0] cfg_inc;
    logic [7:0]         cfg_gain;
    logic [7:0]         lut_addr;
    logic [15:0]        lut_data;
    logic [15:0]        sample_out;
    logic               sample_valid;
    logic               busy;
    logic               overrun;

    modport master (
        output sample_req, cfg_we, cfg_bin, cfg_inc, cfg_gain, lut_data,
        input  lut_addr, sample_out, sample_valid, busy, overrun
    );

    modport slave (
        input  sample_req, cfg_we, cfg_bin, cfg_inc, cfg_gain, lut_data,
        output lut_addr, sample_out, sample_valid, busy, overrun
    );
endinterface

// File: rtl/additive_bin_scheduler.sv
// Shares one combinational 256x16 sine ROM across NUM_BINS oscillators, one lookup per bin
// per sample request, and emits the gain-weighted sum as a 16-bit unsigned sample.
module additive_bin_scheduler #(
    parameter int NUM_BINS = 4,
    parameter int PHASE_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    additive_bin_scheduler_if.slave bus
);
    localparam int BIN_W = $clog2(NUM_BINS);
    localparam int ACC_W = 24 + BIN_W;
    localparam logic [4:0]       BIN_LIMIT = 5'(NUM_BINS);
    localparam logic [BIN_W-1:0] LAST_BIN  = BIN_W'(NUM_BINS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        READ,
        DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [BIN_W-1:0]   bin_idx;
    logic [ACC_W-1:0]   acc;
    logic [PHASE_W-1:0] phase [NUM_BINS];
    logic [PHASE_W-1:0] inc   [NUM_BINS];
    logic [7:0]         gain  [NUM_BINS];
    logic               cfg_hit;
    logic [BIN_W-1:0]   cfg_idx;
    logic [23:0]        product;
    logic [7:0]         lut_addr;
    logic [15:0]        sample_out;
    logic               sample_valid;
    logic               overrun;

    assign cfg_hit = bus.cfg_we && ({1'b0, bus.cfg_bin} < BIN_LIMIT);
    assign cfg_idx = bus.cfg_bin[BIN_W-1:0];
    assign product = {8'd0, bus.lut_data} * {16'd0, gain[bin_idx]};

    assign bus.lut_addr     = lut_addr;
    assign bus.sample_out   = sample_out;
    assign bus.sample_valid = sample_valid;
    assign bus.busy         = (state != IDLE);
    assign bus.overrun      = overrun;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.sample_req) state_next = ADDR;
            ADDR:    state_next = READ;
            READ:    state_next = (bin_idx == LAST_BIN) ? DONE : ADDR;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Config writes land in any state; a READ on the same edge still sees the old values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_BINS; k++) begin
                inc[k]  <= '0;
                gain[k] <= '0;
            end
        end else if (cfg_hit) begin
            inc[cfg_idx]  <= bus.cfg_inc;
            gain[cfg_idx] <= bus.cfg_gain;
        end
    end

    // A bin's phase advances only after its lookup, so the first lookup uses phase 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_BINS; k++) begin
                phase[k] <= '0;
            end
        end else if (state == READ) begin
            phase[bin_idx] <= phase[bin_idx] + inc[bin_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_idx      <= '0;
            acc          <= '0;
            lut_addr     <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.sample_req) begin
                        acc     <= '0;
                        bin_idx <= '0;
                    end
                end
                ADDR: begin
                    lut_addr <= phase[bin_idx][PHASE_W-1 -: 8];
                end
                READ: begin
                    acc <= acc + {{BIN_W{1'b0}}, product};
                    if (bin_idx != LAST_BIN) begin
                        bin_idx <= bin_idx + BIN_W'(1);
                    end
                end
                DONE: begin
                    sample_out   <= acc[ACC_W-1 -: 16];
                    sample_valid <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Requests while a sequence runs are dropped, and that is remembered until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (bus.sample_req && (state != IDLE)) begin
            overrun <= 1'b1;
        end
    end
endmodule

// File: doc/additive_bin_scheduler.md
# additive_bin_scheduler

Time-multiplexes one shared 256×16 combinational sine ROM across `NUM_BINS` additive-synthesis oscillators ("bins"). Each bin has its own phase accumulator, phase increment and gain. On each sample request (one pulse per I2S frame, derived from LRCK), the block sequences one ROM lookup per bin and accumulates the weighted sum. It then presents one 16-bit unsigned sample to the PCM5102 serializer. It sits between the LRCK edge detector, the `mem_sin` ROM and the DAC's left/right inputs.

## Interface
- `NUM_BINS`, default 4: number of oscillators; power of two, 2..16.
- `PHASE_W`, default 16: phase accumulator width; the top 8 bits form the ROM address.
- `BIN_W`, derived, = clog2(`NUM_BINS`).
- `ACC_W`, derived, = 24 + `BIN_W`.

- `clk`  in  1: system clock; the only clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `sample_req`  in  1: one-cycle request for a new sample.
- `cfg_we`  in  1: configuration write strobe.
- `cfg_bin`  in  4: target bin; values ≥ `NUM_BINS` are ignored.
- `cfg_inc`  in  `PHASE_W`: phase increment to write.
- `cfg_gain`  in  8: unsigned gain to write.
- `lut_addr`  out  8: registered ROM address.
- `lut_data`  in  16: unsigned ROM data, combinational from `lut_addr`.
- `sample_out`  out  16: unsigned mixed sample; holds its value between updates.
- `sample_valid`  out  1: one-cycle pulse when `sample_out` updates.
- `busy`  out  1: a sequence is in progress.
- `overrun`  out  1: sticky flag; set when a request arrives while busy; cleared only by reset.

## Operation
- Per-bin registers:
  - `phase[k]` (`PHASE_W`), reset 0.
  - `inc[k]` (`PHASE_W`), reset 0.
  - `gain[k]` (8), reset 0.
- Config: on a `clk` edge with `cfg_we`=1 and `cfg_bin`<`NUM_BINS`, write `inc[cfg_bin]` and `gain[cfg_bin]`.
  - Writes are accepted in any state.
  - A write landing on the same edge as that bin's READ does not affect that READ: the READ uses the pre-edge values.
- FSM states: IDLE, ADDR, READ, DONE. A bin index `b` (`BIN_W` bits) and an accumulator `acc` (`ACC_W` bits) are kept.
  - IDLE: if `sample_req`=1, set `acc`←0, `b`←0, go to ADDR. Otherwise stay.
  - ADDR: `lut_addr`←`phase[b][PHASE_W-1 -: 8]`, go to READ.
  - READ: `acc`←`acc` + `lut_data`×`gain[b]` (16×8 unsigned product, zero-extended); `phase[b]`←`phase[b]`+`inc[b]` (modulo 2^`PHASE_W`, natural wrap).
    - If `b`=`NUM_BINS`-1, go to DONE.
    - Otherwise `b`←`b`+1 and go to ADDR.
  - DONE: `sample_out`←`acc[ACC_W-1 -: 16]`, `sample_valid`←1, go to IDLE.
- Arithmetic: no saturation is needed. The worst case is `NUM_BINS`×65535×255 < 2^`ACC_W`.
- Phase sequence: a bin's first lookup after reset uses phase 0. The phase advances only after that bin is read, so bin k's address on request n is the top 8 bits of (n×`inc[k]`) mod 2^`PHASE_W`.
- `busy` = 1 in ADDR, READ and DONE; 0 in IDLE.
- `sample_req`=1 in any state other than IDLE: the request is ignored and `overrun`←1. An in-progress sequence is never restarted.
- Reset values: `lut_addr`=0, `sample_out`=0, `sample_valid`=0, `busy`=0, `overrun`=0, state IDLE. Reset clears all per-bin registers and `acc` immediately (asynchronous), including mid-sequence; no `sample_valid` is produced for the aborted sequence.

## Timing
- Let E0 be the edge that accepts `sample_req`.
  - Bin k ADDR executes at edge E(1+2k); its READ executes at E(2+2k).
  - DONE executes at E(2·`NUM_BINS`+1).
  - `sample_valid` is high for exactly one cycle after that edge; with `NUM_BINS`=4 this is edge E9.
- `busy` rises after E0 and falls on the same edge `sample_valid` rises.
- A new request may be asserted in the cycle where `sample_valid`=1 (state IDLE); it is accepted without overrun. Minimum request spacing is 2·`NUM_BINS`+2 cycles.
- `lut_data` must settle within one cycle of `lut_addr` changing (combinational ROM).
- `sample_out` is stable for the entire frame between `sample_valid` pulses.

## Test plan
- Reset, then one request with all gains 0 → `busy` is high for 9 cycles; `sample_valid` pulses once 9 edges after acceptance; `sample_out`=0x0000; `overrun`=0.
- ROM model returns 0xFFFF for every address; all gains 0xFF; one request → `sample_out`=0xFEFF (acc = 0x3FBFC04).
- Bin 1 `inc`=0x0280; four requests → bin 1 `lut_addr` = 0x00, 0x02, 0x05, 0x07. Bin 0 `inc`=0x8000 → 0x00, 0x80, 0x00, 0x80.
- Second `sample_req` 3 cycles after the first → exactly one `sample_valid`; `overrun`=1 and stays 1 until reset. A request in the `sample_valid` cycle → accepted; `overrun` stays unchanged.
- `rst_n` low during bin 2 READ → all outputs are 0 immediately; no `sample_valid`. After release, bin 0 `inc`=0x0100, `gain`=1, ROM returns {addr,addr} → first sample uses address 0x00; second sample uses 0x01.
- `cfg_we` with `cfg_bin`=7 (`NUM_BINS`=4) → no register changes. A write to bin 2 during bin 2's READ edge → the current sample uses the old gain; the next sample uses the new gain.
